// File: rtl/lab7_ctrl_pkg.sv
// Shared types and sizing helpers for the accumulate/clear/LED controller.
package lab7_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_t;

  localparam int DEFAULT_DEBOUNCE = 500000;

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus counter debounce for one active-low key;
// emits the debounced level and a one-cycle press pulse on its falling edge.
module key_debouncer
  import lab7_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable_o,
  output logic press_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Registered alongside the stable flop so the pulse lines up with its fall.
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/accum_led_controller.sv
// Key-driven 8-bit accumulator with sticky carry, CPU load port and LED output;
// key operations take priority over a CPU load landing in their commit cycle.
module accum_led_controller
  import lab7_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int DATA_W          = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              accumulate_key_n,
  input  logic              clear_key_n,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              cpu_load,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] led_out,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output ctrl_state_t       dbg_state
);

  logic accum_stable, accum_press;
  logic clear_stable, clear_press;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accum_key (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .key_n    (accumulate_key_n),
    .stable_o (accum_stable),
    .press_o  (accum_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .key_n    (clear_key_n),
    .stable_o (clear_stable),
    .press_o  (clear_press)
  );

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] sw_meta_q, sw_meta_d;
  logic [DATA_W-1:0] sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   sum;

  always_comb begin
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    sum       = {1'b0, acc_q} + {1'b0, sw_sync_q};

    case (state_q)
      IDLE: begin
        if (clear_press)      state_d = CLEAR;
        else if (accum_press) state_d = ACCUM;
      end
      ACCUM: begin
        acc_d   = sum[DATA_W-1:0];
        ovf_d   = ovf_q | sum[DATA_W];
        done_d  = 1'b1;
        state_d = HOLD;
      end
      CLEAR: begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // Wait for a full release so held keys and chords cannot retrigger.
        if (accum_stable && clear_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cpu_load && (state_q != ACCUM) && (state_q != CLEAR)) begin
      acc_d = cpu_data;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign led_out   = acc_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/accum_led_controller.md
Name: accum_led_controller

Overview:
- Hardware sequencer for the switch/accumulate/clear/LED datapath of the lab7 SoC.
- Synchronises and debounces the active-low ACCUMULATE and CLEAR keys and the 8 switches.
- On a debounced ACCUMULATE press, adds the switch value into an 8-bit accumulator; on CLEAR, zeroes it.
- Drives the LEDs from the accumulator and accepts a CPU load port, so the Nios and the keys share one accumulator under fixed priority.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles needed before a key change is accepted (10 ms at 50 MHz); must be >= 2.
- DATA_W, 8, accumulator, switch and LED width.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- accumulate_key_n  in  1  raw ACCUMULATE key, asynchronous, low = pressed.
- clear_key_n  in  1  raw CLEAR key, asynchronous, low = pressed.
- sw_in  in  DATA_W  raw switches, asynchronous.
- cpu_load  in  1  one-cycle strobe: load cpu_data into the accumulator.
- cpu_data  in  DATA_W  CPU load value.
- led_out  out  DATA_W  accumulator value.
- overflow  out  1  sticky carry-out flag.
- busy  out  1  high while the FSM is not IDLE.
- done  out  1  one-cycle pulse when an ACCUM or CLEAR operation commits.

Behaviour:
- Reset (reset_reset_n low at a clock edge) sets:
  - led_out = 0, overflow = 0, busy = 0, done = 0;
  - FSM = IDLE;
  - debounce counters = 0, stable key states = released (1);
  - synchroniser flops = 1 for keys, 0 for switches.
- Reset mid-operation aborts the operation with no commit.
- A key still held when reset deasserts is treated as a new press, accepted after the full debounce time.
- Synchronisers: keys and switches each pass through 2 flops.
- Debounce, per key:
  - The counter increments each cycle the synced value differs from the stable value, and resets to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes the stable value.
- Edge detect: press_pulse = stable 1->0, registered. It is high for exactly one cycle, the cycle after stable falls.
- Latency: with the raw key low continuously from clock edge k, led_out updates at edge k+DEBOUNCE_CYCLES+3 and done pulses in the same cycle.
- FSM states and transitions:
  - IDLE: clear_press -> CLEAR; else accum_press -> ACCUM. If both pulses arrive in the same cycle, CLEAR wins and the accumulate press is discarded.
  - ACCUM (1 cycle):
    - {carry, acc} = {1'b0, acc} + {1'b0, sw_sync}, computed at DATA_W+1 bits.
    - The addition wraps modulo 2^DATA_W.
    - overflow |= carry.
    - done = 1, then go to HOLD.
  - CLEAR (1 cycle): acc = 0, overflow = 0, done = 1, then go to HOLD.
  - HOLD: wait until both stable keys are released, then go to IDLE. Presses in HOLD are ignored, so chords and held keys never double-trigger.
- Switches are sampled only in the ACCUM cycle; the value used is sw_sync from that cycle.
- CPU load:
  - Accepted in any state except ACCUM and CLEAR.
  - A cpu_load in the same cycle as ACCUM or CLEAR is dropped; the key operation has priority.
  - A load sets acc = cpu_data and overflow = 0, does not pulse done, and does not change FSM state.
- Outputs:
  - led_out equals acc, registered with no extra latency.
  - busy = (state != IDLE).

Decomposition:
- Package lab7_ctrl_pkg holds:
  - the state enum ctrl_state_t {IDLE, ACCUM, CLEAR, HOLD};
  - localparam DEFAULT_DEBOUNCE = 500000;
  - a function returning the counter width, $clog2(DEBOUNCE_CYCLES).
- One sub-module, key_debouncer: 2-flop synchroniser, counter, stable register and press_pulse output. It is instantiated twice, for accumulate and clear.
- The switch synchroniser, FSM, accumulator and CPU arbitration stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, sw_in=0x05, hold accumulate_key_n low 10 cycles then release; repeat -> led_out 0x05 then 0x0A. Each update is exactly 7 edges after the key falls, with one done pulse per press.
2. acc=0xFE via cpu_load, sw_in=0x03, accumulate press -> led_out=0x01, overflow=1. A following clear press -> led_out=0x00, overflow=0.
3. Pulse accumulate_key_n low for 3 cycles only -> no done, led_out unchanged. A 1-cycle glitch during a held press does not retrigger.
4. Both keys fall on the same edge, sw_in=0x11 -> CLEAR taken, led_out=0x00, single done. HOLD persists until both keys are released; busy is high throughout.
5. cpu_load with cpu_data=0x80 in the exact ACCUM cycle -> load dropped, led_out = prior+sw. cpu_load=0x80 while in HOLD -> led_out=0x80 next cycle, no done.
6. Assert reset_reset_n low for 1 cycle during HOLD with a key held -> all outputs 0 and IDLE. The held key then yields a press and a commit 7 edges after reset release.
